// File: rtl/cut_seq_pkg.sv
// Shared types and default widths for the CUT pattern sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cut_seq_pkg;

  localparam int N_PI_DEF   = 7;
  localparam int N_PO_DEF   = 4;
  localparam int SETTLE_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_REPORT
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count visible the cycle after inc/clr.
// Backpressure: none; clr has priority over inc.
//
// Ports: clk, rst_n (async active-low), clr (sync clear), inc (count enable),
//        cnt (current count).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cut_pattern_sequencer.sv
// Applies one test vector to a combinational CUT, waits SETTLE cycles, compares masked POs.
// Latency: accept cycle to res_valid = SETTLE+2 cycles; one vector per SETTLE+3 cycles.
// Backpressure: pat_ready only in IDLE; no pipelining, pat_valid ignored while busy.
//
// Ports: clk, rst_n (async active-low), clr (clear counters/sticky, IDLE only);
//        pat_valid/pat_ready handshake with pat_pi, pat_exp, pat_mask;
//        cut_pi -> CUT inputs, cut_po <- CUT outputs;
//        res_valid pulse with res_fail/res_diff; busy; pat_count, fail_count, sticky_fail.
module cut_pattern_sequencer
  import cut_seq_pkg::*;
#(
  parameter int N_PI   = N_PI_DEF,
  parameter int N_PO   = N_PO_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [N_PI-1:0]  pat_pi,
  input  logic [N_PO-1:0]  pat_exp,
  input  logic [N_PO-1:0]  pat_mask,
  output logic [N_PI-1:0]  cut_pi,
  input  logic [N_PO-1:0]  cut_po,
  output logic             res_valid,
  output logic             res_fail,
  output logic [N_PO-1:0]  res_diff,
  output logic             busy,
  output logic [CNT_W-1:0] pat_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             sticky_fail
);

  // Settle counter holds SETTLE-1 down to 0.
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [N_PI-1:0]  cut_pi_q, cut_pi_d;
  logic [N_PO-1:0]  exp_q, exp_d;
  logic [N_PO-1:0]  mask_q, mask_d;
  logic [N_PO-1:0]  res_diff_q, res_diff_d;
  logic             sticky_q, sticky_d;
  logic             cnt_clr;
  logic             pat_inc;
  logic             fail_inc;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    cut_pi_d     = cut_pi_q;
    exp_d        = exp_q;
    mask_d       = mask_q;
    res_diff_d   = res_diff_q;
    sticky_d     = sticky_q;
    cnt_clr      = 1'b0;
    pat_inc      = 1'b0;
    fail_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // clr and accept may coincide: counters clear, vector still taken.
        if (clr) begin
          cnt_clr  = 1'b1;
          sticky_d = 1'b0;
        end
        if (pat_valid) begin
          cut_pi_d     = pat_pi;
          exp_d        = pat_exp;
          mask_d       = pat_mask;
          settle_cnt_d = SC_W'(SETTLE - 1);
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q - SC_W'(1);
        end
      end
      S_CAPTURE: begin
        // Registering the masked difference captures the POs; the result
        // fields then change only on entry to REPORT and hold until the next one.
        res_diff_d = (cut_po ^ exp_q) & mask_q;
        state_d    = S_REPORT;
      end
      S_REPORT: begin
        pat_inc  = 1'b1;
        fail_inc = |res_diff_q;
        sticky_d = sticky_q | (|res_diff_q);
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      cut_pi_q     <= '0;
      exp_q        <= '0;
      mask_q       <= '0;
      res_diff_q   <= '0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      cut_pi_q     <= cut_pi_d;
      exp_q        <= exp_d;
      mask_q       <= mask_d;
      res_diff_q   <= res_diff_d;
      sticky_q     <= sticky_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (pat_inc),
    .cnt   (pat_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (fail_inc),
    .cnt   (fail_count)
  );

  assign pat_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign res_valid   = (state_q == S_REPORT);
  assign res_fail    = |res_diff_q;
  assign res_diff    = res_diff_q;
  assign cut_pi      = cut_pi_q;
  assign sticky_fail = sticky_q;

endmodule

// File: tb/tb_cut_pattern_sequencer.sv
// Scoreboard bench: driver pushes expected results at accept; a monitor pops on res_valid.
// Latency: checks res_valid arrives SETTLE+2 cycles after accept.
// Backpressure: checks pat_ready/busy against a cycle model of the sequencer occupancy.
module tb_cut_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        pat_valid = 1'b0;
  logic [6:0]  pat_pi = '0;
  logic [3:0]  pat_exp = '0;
  logic [3:0]  pat_mask = '0;

  logic        pat_ready, res_valid, res_fail, busy, sticky_fail;
  logic [6:0]  cut_pi;
  logic [3:0]  cut_po, res_diff;
  logic [15:0] pat_count, fail_count;

  logic        s_pat_ready, s_res_valid, s_res_fail, s_busy, s_sticky_fail;
  logic [6:0]  s_cut_pi;
  logic [3:0]  s_cut_po, s_res_diff;
  logic [2:0]  s_pat_count, s_fail_count;

  always #5 clk = ~clk;

  // Reference CUT behaviour.
  function automatic logic [3:0] cut_fn(input logic [6:0] pi);
    return {pi[6] | pi[0], ~(pi[4] | pi[5]), pi[2] & pi[3], pi[0] ^ pi[1]};
  endfunction

  assign cut_po   = cut_fn(cut_pi);
  assign s_cut_po = cut_fn(s_cut_pi);

  cut_pattern_sequencer #(.N_PI(7), .N_PO(4), .SETTLE(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_pi(pat_pi), .pat_exp(pat_exp), .pat_mask(pat_mask),
    .cut_pi(cut_pi), .cut_po(cut_po),
    .res_valid(res_valid), .res_fail(res_fail), .res_diff(res_diff),
    .busy(busy), .pat_count(pat_count), .fail_count(fail_count),
    .sticky_fail(sticky_fail)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  cut_pattern_sequencer #(.N_PI(7), .N_PO(4), .SETTLE(2), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .pat_valid(pat_valid), .pat_ready(s_pat_ready),
    .pat_pi(pat_pi), .pat_exp(pat_exp), .pat_mask(pat_mask),
    .cut_pi(s_cut_pi), .cut_po(s_cut_po),
    .res_valid(s_res_valid), .res_fail(s_res_fail), .res_diff(s_res_diff),
    .busy(s_busy), .pat_count(s_pat_count), .fail_count(s_fail_count),
    .sticky_fail(s_sticky_fail)
  );

  // Directed vectors: pi, expected PO, mask, hand-computed masked diff.
  logic [6:0] t_pi   [8] = '{7'h00, 7'h00, 7'h00, 7'h7F, 7'h01, 7'h0C, 7'h32, 7'h40};
  logic [3:0] t_exp  [8] = '{4'h4,  4'h6,  4'h6,  4'hA,  4'h0,  4'h9,  4'h1,  4'h0};
  logic [3:0] t_mask [8] = '{4'hF,  4'hF,  4'hD,  4'hF,  4'h0,  4'hF,  4'h8,  4'h7};
  logic [3:0] t_diff [8] = '{4'h0,  4'h2,  4'h0,  4'h0,  4'h0,  4'hF,  4'h0,  4'h4};

  typedef struct {
    logic [3:0] diff;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         busy_until = -1;
  logic [6:0] last_pi = '0;
  int         exp_pat = 0;
  int         exp_fl = 0;
  logic       exp_sticky = 1'b0;
  logic [3:0] exp_res = '0;
  logic       exp_busy;
  bit         b2b_mode = 1'b0;
  int         last_res = -1;
  int         n_res = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  // Offer vector idx, wait for the handshake, record the expectation.
  task automatic send(input int idx, input bit keep, input bit discard);
    pat_valid = 1'b1;
    pat_pi    = t_pi[idx];
    pat_exp   = t_exp[idx];
    pat_mask  = t_mask[idx];
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (pat_ready) break;
    end
    chk("accept_ready", 32'(pat_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!discard) sb.push_back('{diff: t_diff[idx], cyc: cyc + 3});
    busy_until = cyc + 3;
    last_pi    = t_pi[idx];
    if (!keep) pat_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 60 && (sb.size() != 0 || cyc <= busy_until); w++) @(negedge clk);
    chk("drain_pending", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_pat = 0; exp_fl = 0; exp_sticky = 1'b0; exp_res = '0;
        end
        if (res_valid) begin
          if (sb.size() == 0) begin
            chk("res_valid_unexpected", 32'(res_valid), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_latency", cyc, e.cyc);
            exp_res = e.diff;
            if (b2b_mode && last_res >= 0) chk("b2b_spacing", cyc - last_res, 32'd5);
            last_res = cyc;
            n_res++;
          end
        end
        exp_busy = (cyc <= busy_until);
        chk("res_diff",    32'(res_diff),    32'(exp_res));
        chk("res_fail",    32'(res_fail),    32'(|exp_res));
        chk("s_res_diff",  32'(s_res_diff),  32'(exp_res));
        chk("busy",        32'(busy),        32'(exp_busy));
        chk("pat_ready",   32'(pat_ready),   32'(!exp_busy));
        chk("cut_pi",      32'(cut_pi),      32'(last_pi));
        chk("pat_count",   32'(pat_count),   exp_pat);
        chk("fail_count",  32'(fail_count),  exp_fl);
        chk("sticky_fail", 32'(sticky_fail), 32'(exp_sticky));
        chk("s_pat_count", 32'(s_pat_count), sat7(exp_pat));
        chk("s_fail_count",32'(s_fail_count),sat7(exp_fl));
        if (res_valid) begin
          exp_pat++;
          if (|exp_res) begin
            exp_fl++;
            exp_sticky = 1'b1;
          end
        end
        if (clr && !exp_busy && rst_n) begin
          exp_pat = 0; exp_fl = 0; exp_sticky = 1'b0;
        end
      end
    join_none

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed pass / fail / masked / mask-zero vectors
    for (int i = 0; i < 8; i++) send(i, 1'b0, 1'b0);
    drain();

    // Back-to-back with pat_valid held high
    b2b_mode = 1'b1;
    last_res = -1;
    n_res    = 0;
    for (int i = 0; i < 10; i++) send(i % 8, 1'b1, 1'b0);
    pat_valid = 1'b0;
    drain();
    b2b_mode = 1'b0;
    chk("b2b_count", n_res, 32'd10);

    // clr in IDLE, then clr while busy is ignored
    clr_pulse();
    send(1, 1'b0, 1'b0);
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    drain();

    // Saturation of the narrow counters
    clr_pulse();
    for (int i = 0; i < 9; i++) send(1, 1'b0, 1'b0);
    drain();
    chk("sat_s_pat",  32'(s_pat_count),  32'd7);
    chk("sat_s_fail", 32'(s_fail_count), 32'd7);
    chk("wide_pat",   32'(pat_count),    32'd9);

    // Reset during SETTLE discards the in-flight vector
    send(3, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    busy_until = -1;
    last_pi    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Recovery after reset
    send(5, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
